// File: rtl/traffic_sensor_conditioner_if.sv
// ----------------------------------------------------------------------------
// traffic_sensor_conditioner_if
//   Bundles the loop-detector inputs and the conditioned presence / count
//   outputs of traffic_sensor_conditioner.
//
//   SA_raw, SB_raw : raw asynchronous loop detectors (street A / street B)
//   clr_cnt        : synchronous clear of both vehicle counters
//   TA, TB         : conditioned traffic-present flags
//   CA, CB         : saturating vehicle-arrival counters, CNT_W bits
//
//   master : the side that drives the detectors (testbench / sensor front end)
//   slave  : the conditioner itself
// ----------------------------------------------------------------------------
interface traffic_sensor_conditioner_if #(
  parameter int unsigned CNT_W = 8
);

  logic             SA_raw;
  logic             SB_raw;
  logic             clr_cnt;
  logic             TA;
  logic             TB;
  logic [CNT_W-1:0] CA;
  logic [CNT_W-1:0] CB;

  modport master (
    output SA_raw,
    output SB_raw,
    output clr_cnt,
    input  TA,
    input  TB,
    input  CA,
    input  CB
  );

  modport slave (
    input  SA_raw,
    input  SB_raw,
    input  clr_cnt,
    output TA,
    output TB,
    output CA,
    output CB
  );

endinterface

// File: rtl/traffic_sensor_conditioner.sv
// ----------------------------------------------------------------------------
// traffic_sensor_conditioner
//   Conditions two raw vehicle loop detectors for a traffic-light controller.
//   Each street has an identical, independent lane made of:
//     2-flop synchronizer -> debouncer -> presence FSM (IDLE/PRESENT/HOLD)
//     -> saturating arrival counter.
//
//   Parameters
//     DEBOUNCE : consecutive synced cycles needed to accept a level change (1..255)
//     HOLD     : cycles the presence flag stays high after a vehicle clears (0..255)
//     CNT_W    : arrival counter width
//
//   Ports
//     clk : single clock, rising edge
//     rst : synchronous, active-high reset
//     bus : traffic_sensor_conditioner_if.slave
//           (SA_raw, SB_raw, clr_cnt in; TA, TB, CA, CB out)
// ----------------------------------------------------------------------------

// One conditioning lane: synchronizer, debouncer, presence FSM and counter.
module traffic_sensor_lane #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw,
  input  logic             clr_cnt,
  output logic             t,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned      DW      = 8;
  localparam logic [DW-1:0]    DC_LAST = DW'(DEBOUNCE - 1);
  // With HOLD == 0 the HOLD state is never entered, so the value is unused.
  localparam logic [DW-1:0]    HC_LAST = DW'((HOLD == 0) ? 0 : HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  logic          sync1;
  logic          s;
  logic          f;
  logic [DW-1:0] dc;
  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] hc;
  logic [DW-1:0] hc_nxt;
  logic          arrive;

  // Two-flop synchronizer for the asynchronous detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // Debouncer: f follows s only after DEBOUNCE consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      f  <= 1'b0;
      dc <= '0;
    end else if (s != f) begin
      if (dc == DC_LAST) begin
        f  <= s;
        dc <= '0;
      end else begin
        dc <= dc + DW'(1);
      end
    end else begin
      dc <= '0;
    end
  end

  // Presence FSM state register; t is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hc    <= '0;
      t     <= 1'b0;
    end else begin
      state <= state_nxt;
      hc    <= hc_nxt;
      t     <= (state_nxt != ST_IDLE);
    end
  end

  // Presence FSM next-state; a retrigger from HOLD counts as a new vehicle.
  always_comb begin
    state_nxt = state;
    hc_nxt    = hc;
    arrive    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (f) begin
          state_nxt = ST_PRESENT;
          arrive    = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (!f) begin
          if (HOLD == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_HOLD;
            hc_nxt    = '0;
          end
        end
      end
      ST_HOLD: begin
        if (f) begin
          state_nxt = ST_PRESENT;
          arrive    = 1'b1;
        end else if (hc == HC_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          hc_nxt = hc + DW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Saturating arrival counter; a clear coinciding with an arrival leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= arrive ? CNT_W'(1) : '0;
    end else if (arrive && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

module traffic_sensor_conditioner #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  traffic_sensor_conditioner_if.slave   bus
);

  // Street A lane.
  traffic_sensor_lane #(
    .DEBOUNCE (DEBOUNCE),
    .HOLD     (HOLD),
    .CNT_W    (CNT_W)
  ) u_lane_a (
    .clk     (clk),
    .rst     (rst),
    .raw     (bus.SA_raw),
    .clr_cnt (bus.clr_cnt),
    .t       (bus.TA),
    .cnt     (bus.CA)
  );

  // Street B lane.
  traffic_sensor_lane #(
    .DEBOUNCE (DEBOUNCE),
    .HOLD     (HOLD),
    .CNT_W    (CNT_W)
  ) u_lane_b (
    .clk     (clk),
    .rst     (rst),
    .raw     (bus.SB_raw),
    .clr_cnt (bus.clr_cnt),
    .t       (bus.TB),
    .cnt     (bus.CB)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// ----------------------------------------------------------------------------
// tb_traffic_sensor_conditioner
//   Cycle-by-cycle vector table for reset, debounce, hold, retrigger,
//   simultaneous arrivals, counter clear and mid-operation reset, followed by
//   hand-written sequences for counter saturation and clear-with-arrival.
//   Expected outputs are queued when a stimulus cycle is driven and popped
//   once the DUT has clocked it.
// ----------------------------------------------------------------------------
module tb_traffic_sensor_conditioner;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic             ta;
    logic             tb;
    logic [CNT_W-1:0] ca;
    logic [CNT_W-1:0] cb;
  } exp_t;

  typedef struct {
    logic  sa;
    logic  sb;
    logic  clr;
    logic  rst;
    exp_t  exp;
    string tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  traffic_sensor_conditioner_if #(.CNT_W(CNT_W)) bus ();

  traffic_sensor_conditioner #(
    .DEBOUNCE (4),
    .HOLD     (8),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Append n identical per-cycle records to the vector table.
  task automatic add(input int n, input logic sa, input logic sb, input logic clr,
                     input logic r, input logic ta, input logic tb,
                     input int ca, input int cb, input string tag);
    vec_t v;
    v.sa  = sa;
    v.sb  = sb;
    v.clr = clr;
    v.rst = r;
    v.exp = '{ta: ta, tb: tb, ca: CNT_W'(ca), cb: CNT_W'(cb)};
    v.tag = tag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive one cycle of inputs without queuing an expectation.
  task automatic drive(input logic sa, input logic sb, input logic clr, input logic r);
    @(negedge clk);
    bus.SA_raw  = sa;
    bus.SB_raw  = sb;
    bus.clr_cnt = clr;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare against the DUT outputs.
  task automatic compare(input string tag);
    exp_t e;
    exp_t a;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    a = '{ta: bus.TA, tb: bus.TB, ca: bus.CA, cb: bus.CB};
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got TA=%0b TB=%0b CA=%0d CB=%0d, expected TA=%0b TB=%0b CA=%0d CB=%0d",
               tag, $time, a.ta, a.tb, a.ca, a.cb, e.ta, e.tb, e.ca, e.cb);
    end
  endtask

  // Drive one cycle, queue what the outputs must be after the edge, check it.
  task automatic step(input logic sa, input logic sb, input logic clr, input logic r,
                      input exp_t e, input string tag);
    @(negedge clk);
    bus.SA_raw  = sa;
    bus.SB_raw  = sb;
    bus.clr_cnt = clr;
    rst         = r;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int   exp_ca;
    exp_t e;

    bus.SA_raw  = 1'b0;
    bus.SB_raw  = 1'b0;
    bus.clr_cnt = 1'b0;
    rst         = 1'b1;

    //   n  sa sb clr rst  ta tb ca cb
    add( 2, 1, 1, 1,  1,   0, 0, 0, 0, "reset");
    // 3-cycle glitch on A never passes the debouncer.
    add( 3, 1, 0, 0,  0,   0, 0, 0, 0, "glitch_hi");
    add( 8, 0, 0, 0,  0,   0, 0, 0, 0, "glitch_lo");
    // A held high: TA rises after the 7th edge, CA counts once.
    add( 6, 1, 0, 0,  0,   0, 0, 0, 0, "a_latency");
    add( 4, 1, 0, 0,  0,   1, 0, 1, 0, "a_present");
    // Short gap: enters HOLD, then retriggers before the hold expires.
    add( 5, 0, 0, 0,  0,   1, 0, 1, 0, "a_gap");
    add( 6, 1, 0, 0,  0,   1, 0, 1, 0, "a_hold");
    add( 5, 1, 0, 0,  0,   1, 0, 2, 0, "a_retrig");
    // A clears: f drops after 6, HOLD after 7, IDLE after 15.
    add(14, 0, 0, 0,  0,   1, 0, 2, 0, "a_hold_tail");
    add( 2, 0, 0, 0,  0,   0, 0, 2, 0, "a_idle");
    // Simultaneous arrivals are both counted on the same edge.
    add( 6, 1, 1, 0,  0,   0, 0, 2, 0, "ab_latency");
    add( 4, 1, 1, 0,  0,   1, 1, 3, 1, "ab_present");
    // Counter clear leaves presence untouched.
    add( 1, 1, 1, 1,  0,   1, 1, 0, 0, "clr_only");
    add( 1, 1, 1, 0,  0,   1, 1, 0, 0, "clr_after");
    // B released into HOLD, then reset mid-operation (reset beats clr_cnt).
    add( 8, 1, 0, 0,  0,   1, 1, 0, 0, "b_hold");
    add( 1, 1, 1, 1,  1,   0, 0, 0, 0, "rst_mid");
    // Inputs already high at release are fresh arrivals with full latency.
    add( 6, 1, 1, 0,  0,   0, 0, 0, 0, "rel_latency");
    add( 3, 1, 1, 0,  0,   1, 1, 1, 1, "rel_present");

    foreach (vecs[i]) begin
      step(vecs[i].sa, vecs[i].sb, vecs[i].clr, vecs[i].rst, vecs[i].exp, vecs[i].tag);
    end

    // Saturation: repeated full arrivals on A while B stays present.
    exp_ca = 1;
    for (int it = 0; it < 255; it++) begin
      for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++)  drive(1'b1, 1'b1, 1'b0, 1'b0);
      exp_ca = (exp_ca == 255) ? 255 : exp_ca + 1;
      e = '{ta: 1'b1, tb: 1'b1, ca: CNT_W'(exp_ca), cb: CNT_W'(1)};
      step(1'b1, 1'b1, 1'b0, 1'b0, e, (it == 254) ? "ca_saturate" : "ca_count");
    end

    // Clear on the very edge of a new arrival leaves CA at 1, CB at 0.
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)  drive(1'b1, 1'b1, 1'b0, 1'b0);
    e = '{ta: 1'b1, tb: 1'b1, ca: CNT_W'(1), cb: CNT_W'(0)};
    step(1'b1, 1'b1, 1'b1, 1'b0, e, "clr_with_arrival");
    step(1'b1, 1'b1, 1'b0, 1'b0, e, "clr_with_arrival_hold");

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
